// File: rtl/i2c_bus_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_bus_pkg : shared bus-state type and default sizing for i2c_bus_resolver
// Revision    : 1.0
// ----------------------------------------------------------------------------
package i2c_bus_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bus_state_e;

  localparam int DEF_NUM_DEV     = 2;
  localparam int DEF_FILT_LEN    = 3;
  localparam int DEF_TIMEOUT_CYC = 1000;

  // Open-drain: only an enabled driver presenting 0 actually pulls the wire.
  function automatic logic pulls_low(input logic oen, input logic o);
    return oen & ~o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_line_filter : 2-flop synchroniser plus stability counter for one line
// Revision        : 1.0
// ----------------------------------------------------------------------------
module i2c_line_filter
  import i2c_bus_pkg::*;
#(
  parameter int FILT_LEN = DEF_FILT_LEN
) (
  input  logic pclk,
  input  logic areset,
  input  logic line,
  output logic filt
);

  localparam int            CW     = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(FILT_LEN - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;

  // A sample equal to the current output restarts the run, so only an
  // unbroken run of FILT_LEN opposite samples moves the output.
  always_ff @(posedge pclk) begin
    if (areset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_cnt   <= '0;
      filt    <= 1'b1;
    end else begin
      r_sync1 <= line;
      r_sync2 <= r_sync1;
      if (r_sync2 == filt) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        filt  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_bus_resolver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_bus_resolver : wired-AND I2C bus with filtering, bus-state tracking,
//                    arbitration-loss, clock-stretch and timeout detection
// Revision         : 1.0
// ----------------------------------------------------------------------------
module i2c_bus_resolver
  import i2c_bus_pkg::*;
#(
  parameter int NUM_DEV     = DEF_NUM_DEV,
  parameter int FILT_LEN    = DEF_FILT_LEN,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic               pclk,
  input  logic               areset,
  input  logic [NUM_DEV-1:0] scl_o,
  input  logic [NUM_DEV-1:0] scl_oen,
  input  logic [NUM_DEV-1:0] sda_o,
  input  logic [NUM_DEV-1:0] sda_oen,
  input  logic [NUM_DEV-1:0] arb_en,
  output logic               scl,
  output logic               sda,
  output logic               scl_i,
  output logic               sda_i,
  output logic               bus_busy,
  output logic               start_det,
  output logic               repstart_det,
  output logic               stop_det,
  output logic [NUM_DEV-1:0] arb_lost,
  output logic               stretch_active,
  output logic               bus_timeout
);

  localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] C_TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] C_TO_MAX  = TW'(TIMEOUT_CYC);
  localparam int            SETTLE    = FILT_LEN + 3;
  localparam int            SW        = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] C_SETTLE  = SW'(SETTLE);

  logic [NUM_DEV-1:0] w_scl_pull;
  logic [NUM_DEV-1:0] w_sda_pull;

  generate
    for (genvar d = 0; d < NUM_DEV; d++) begin : g_dev
      assign w_scl_pull[d] = pulls_low(scl_oen[d], scl_o[d]);
      assign w_sda_pull[d] = pulls_low(sda_oen[d], sda_o[d]);
    end
  endgenerate

  assign scl = ~|w_scl_pull;
  assign sda = ~|w_sda_pull;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .pclk   (pclk),
    .areset (areset),
    .line   (scl),
    .filt   (scl_i)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .pclk   (pclk),
    .areset (areset),
    .line   (sda),
    .filt   (sda_i)
  );

  bus_state_e    r_state;
  logic          r_scl_prev;
  logic          r_sda_prev;
  logic [TW-1:0] r_to_cnt;
  logic [SW-1:0] r_settle;

  logic w_events_en;
  logic w_scl_high;
  logic w_start;
  logic w_stop;
  logic w_scl_rise;
  logic w_counting;
  logic w_timeout;

  // Lines held low through reset reach the filters' outputs as ordinary
  // edges; those first 2+FILT_LEN cycles are settling, not bus conditions.
  assign w_events_en = (r_settle == C_SETTLE);
  // SCL must be high both before and after, so a simultaneous SCL/SDA
  // change never reads as START or STOP.
  assign w_scl_high  = r_scl_prev & scl_i;
  assign w_start     = w_events_en & w_scl_high &  r_sda_prev & ~sda_i;
  assign w_stop      = w_events_en & w_scl_high & ~r_sda_prev &  sda_i;
  assign w_scl_rise  = ~r_scl_prev & scl_i;
  assign w_counting  = (r_state == BUSY) & ~scl_i;
  assign w_timeout   = w_counting & ~w_start & (r_to_cnt == C_TO_LAST);

  always_ff @(posedge pclk) begin
    if (areset) begin
      r_state        <= IDLE;
      r_scl_prev     <= 1'b1;
      r_sda_prev     <= 1'b1;
      r_to_cnt       <= '0;
      r_settle       <= '0;
      bus_busy       <= 1'b0;
      start_det      <= 1'b0;
      repstart_det   <= 1'b0;
      stop_det       <= 1'b0;
      arb_lost       <= '0;
      stretch_active <= 1'b0;
      bus_timeout    <= 1'b0;
    end else begin
      r_scl_prev   <= scl_i;
      r_sda_prev   <= sda_i;
      if (r_settle != C_SETTLE) begin
        r_settle <= r_settle + 1'b1;
      end

      start_det      <= w_start;
      stop_det       <= w_stop;
      repstart_det   <= w_start & (r_state == BUSY);
      bus_timeout    <= w_timeout;
      stretch_active <= ~scl_i & |(arb_en & ~w_scl_pull);

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state  <= BUSY;
            bus_busy <= 1'b1;
          end
        end
        BUSY: begin
          if (!w_start && (w_stop || w_timeout)) begin
            r_state  <= IDLE;
            bus_busy <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          bus_busy <= 1'b0;
        end
      endcase

      if (!w_counting || w_start || w_timeout) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != C_TO_MAX) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      // A master that released SDA but sees it low on the SCL rise has lost.
      if (w_stop || w_timeout) begin
        arb_lost <= '0;
      end else if (w_scl_rise) begin
        arb_lost <= arb_lost | (arb_en & ~w_sda_pull & {NUM_DEV{~sda_i}});
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/i2c_bus_resolver.md
# i2c_bus_resolver

Parametrised, synthesisable successor to the single-pair I2C interface. It resolves NUM_DEV open-drain SCL/SDA drivers into one wired-AND bus and synchronises and de-glitches both lines. It also tracks bus state (START, repeated START, STOP, busy), flags per-device arbitration loss and clock stretching, and recovers a hung bus by timeout. It sits in hdl_top between the master/slave driver BFMs and the bus, replacing the tri-state and pull-up modelling.

## Interface
- NUM_DEV, 2: number of devices on the bus (≥2).
- FILT_LEN, 3: cycles a synchronised line must be stable before the filtered value changes (≥1).
- TIMEOUT_CYC, 1000: cycles SCL may stay low while busy before a timeout (≥4).

- pclk  in  1  system clock.
- areset  in  1  synchronous, active-high reset.
- scl_o  in  NUM_DEV  per-device SCL output value.
- scl_oen  in  NUM_DEV  per-device SCL output enable.
- sda_o  in  NUM_DEV  per-device SDA output value.
- sda_oen  in  NUM_DEV  per-device SDA output enable.
- arb_en  in  NUM_DEV  device is currently a master transmitter; enables arbitration and stretch checks for it.
- scl  out  1  raw resolved SCL (combinational).
- sda  out  1  raw resolved SDA (combinational).
- scl_i  out  1  filtered SCL, fanned to all devices.
- sda_i  out  1  filtered SDA, fanned to all devices.
- bus_busy  out  1  level: START seen, no STOP or timeout yet.
- start_det  out  1  one-cycle pulse on any START.
- repstart_det  out  1  one-cycle pulse on a START while busy.
- stop_det  out  1  one-cycle pulse on STOP.
- arb_lost  out  NUM_DEV  sticky per-device arbitration-loss flag.
- stretch_active  out  1  level: SCL held low by a device other than a releasing arb_en device.
- bus_timeout  out  1  one-cycle pulse on timeout.

## Operation
- Pure open-drain resolution: a device pulls low only when oen=1 and o=0. oen=1 with o=1 counts as release.
  - scl = AND over d of ~(scl_oen[d] & ~scl_o[d]); sda is resolved the same way. An idle line reads 1.
- Each line passes through a 2-flop synchroniser, then a stability counter.
  - The filtered output takes a new value only after FILT_LEN consecutive equal synchronised samples.
  - Any differing sample restarts the count, so shorter pulses are rejected.
- START: filtered SDA 1→0 while filtered SCL=1. STOP: filtered SDA 0→1 while filtered SCL=1.
- FSM (package enum): IDLE, BUSY.
  - IDLE→BUSY on START.
  - BUSY→BUSY on START: repstart_det=1, start_det=1.
  - BUSY→IDLE on STOP or timeout.
  - STOP in IDLE still pulses stop_det; the state is unchanged.
- Arbitration: on each filtered SCL rising edge, arb_lost[d] is set if arb_en[d]=1, device d is releasing SDA, and filtered SDA=0.
  - arb_lost is cleared on STOP, timeout or reset.
  - A START does not clear it.
- stretch_active = 1 when filtered SCL=0 and some device with arb_en=1 is releasing SCL.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYC+1); saturating.
  - Counts cycles with bus_busy=1 and filtered SCL=0; clears on filtered SCL=1, IDLE, or START.
  - When it reaches TIMEOUT_CYC: pulse bus_timeout, go to IDLE, clear the counter.

## Timing
- Reset values:
  - Sync flops, scl_i and sda_i: 1.
  - Filter counters and timeout counter: 0.
  - State: IDLE.
  - bus_busy, start_det, repstart_det, stop_det, arb_lost, bus_timeout, stretch_active: 0.
- Raw line to scl_i/sda_i latency: 2+FILT_LEN cycles for a clean edge.
- Event pulses (start/stop/repstart) assert one cycle after the filtered edge that causes them. bus_busy follows the same cycle.
- arb_lost asserts one cycle after the filtered SCL rising edge.
- Simultaneous events:
  - START and timeout in the same cycle: START wins, state stays BUSY, counter clears, no bus_timeout.
  - Filtered SCL and SDA changing in the same cycle: evaluate against the previous SCL value, so no START/STOP.
- Reset mid-transfer: everything returns to reset values. A line held low at reset release reaches scl_i/sda_i 2+FILT_LEN cycles later and generates no START/STOP.

## Structure
- Package i2c_bus_pkg holds:
  - bus_state_e {IDLE, BUSY};
  - default parameter constants.
- Sub-module i2c_line_filter (synchroniser plus stability counter, FILT_LEN parameter), instantiated once for SCL and once for SDA.
- The top level holds the resolution logic, edge detection, FSM, arbitration, stretch and timeout logic.

## Test plan
- Reset release, all devices released -> scl_i=sda_i=1, bus_busy=0, no pulses.
- FILT_LEN=3: SDA glitch low for 2 cycles -> sda_i stays 1. Glitch of 3 cycles -> sda_i=0 at cycle 5.
- Device 0 issues START, 8 bits, STOP -> start_det at START+6 cycles, bus_busy high, stop_det once, bus_busy=0.
- Two arb_en masters: bit 3 has dev0=1, dev1=0 -> arb_lost=2'b01 after the SCL rise; it holds through a repeated START and clears on STOP.
- Slave holds SCL low 50 cycles while master releases -> stretch_active=1 for those cycles. TIMEOUT_CYC=40 -> bus_timeout pulse at cycle 40, bus_busy=0.
- Reset asserted mid-byte with SDA held low -> all outputs return to reset values; no start_det after release.
